// File: rtl/seven_seg_pkg.sv
// Shared constants, glyph decode and converter state encoding for the
// multiplexed seven-segment numeric driver.
package seven_seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } conv_state_t;

    // Active-low segments ordered g..a; letters b, c, d lowercase, A, E, F uppercase.
    function automatic logic [6:0] seg_glyph(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'ha: seg = 7'b0001000;
            4'hb: seg = 7'b0000011;
            4'hc: seg = 7'b0100111;
            4'hd: seg = 7'b0100001;
            4'he: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one captured bit per SHIFT cycle,
// a single COMMIT cycle flagged by done, then back to IDLE.
module bin2bcd_seq
    import seven_seg_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      value,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf,
    output logic                  done
);
    localparam int BW = 4*DIGITS;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    conv_state_t      state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic [BW-1:0]    adj;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
            bcd   <= '0;
            ovf   <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sreg  <= value;
                        cnt   <= '0;
                        bcd   <= '0;
                        ovf   <= 1'b0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd  <= {adj[BW-2:0], sreg[WIDTH-1]};
                    ovf  <= ovf | adj[BW-1];
                    sreg <= sreg << 1;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH-1)) begin
                        state <= COMMIT;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/seven_seg_num.sv
// Multiplexed common-anode numeric display driver: free-running capture and
// conversion, atomic display commit, leading-zero blanking and digit scan.
module seven_seg_num
    import seven_seg_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int WIDTH          = 16,
    parameter int REFRESH_CYCLES = 262144
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  num,
    input  logic              hex_mode,
    input  logic              blank_lz,
    input  logic [DIGITS-1:0] dp_mask,
    output logic [6:0]        sseg,
    output logic [DIGITS-1:0] an,
    output logic              dp,
    output logic              busy
);
    localparam int BW = 4*DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int RW = $clog2(REFRESH_CYCLES);

    logic [WIDTH-1:0]         cap_num;
    logic                     cap_hex;
    logic                     cap_blz;
    logic [BW-1:0]            bcd;
    logic                     bcd_ovf;
    logic                     done;
    logic [DIGITS-1:0][6:0]   disp;
    logic [DIGITS-1:0][6:0]   next_disp;
    logic [BW+WIDTH-1:0]      ext;
    logic                     show_ovf;
    logic                     leading;
    logic [3:0]               nib;
    logic [RW-1:0]            rcnt;
    logic [IW-1:0]            idx;

    bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (~busy),
        .value (num),
        .bcd   (bcd),
        .ovf   (bcd_ovf),
        .done  (done)
    );

    // Frame to commit, scanned leftmost first so blanking stops at the first nonzero digit.
    always_comb begin
        ext       = (BW+WIDTH)'(cap_num);
        show_ovf  = cap_hex ? |(ext >> BW) : bcd_ovf;
        leading   = cap_blz;
        nib       = '0;
        next_disp = '1;
        for (int i = DIGITS-1; i >= 0; i--) begin
            nib = cap_hex ? ext[4*i +: 4] : bcd[4*i +: 4];
            if (show_ovf) begin
                next_disp[i] = SEG_DASH;
            end else if (leading && nib == 4'd0 && i != 0) begin
                next_disp[i] = SEG_BLANK;
            end else begin
                next_disp[i] = seg_glyph(nib);
                leading      = 1'b0;
            end
        end
    end

    // busy is low only for the single IDLE cycle in which inputs are captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            cap_num <= '0;
            cap_hex <= 1'b0;
            cap_blz <= 1'b0;
            // NOTE: the display register is small and must read blank after reset, so it is reset explicitly.
            disp    <= '1;
        end else if (!busy) begin
            busy    <= 1'b1;
            cap_num <= num;
            cap_hex <= hex_mode;
            cap_blz <= blank_lz;
        end else if (done) begin
            busy    <= 1'b0;
            disp    <= next_disp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt <= '0;
            idx  <= IW'(DIGITS-1);
            sseg <= SEG_BLANK;
            an   <= '1;
            dp   <= 1'b1;
        end else begin
            if (rcnt == RW'(REFRESH_CYCLES-1)) begin
                rcnt <= '0;
                idx  <= (idx == '0) ? IW'(DIGITS-1) : idx - 1'b1;
            end else begin
                rcnt <= rcnt + 1'b1;
            end
            sseg <= disp[idx];
            an   <= ~(DIGITS'(1) << idx);
            dp   <= ~dp_mask[idx];
        end
    end

endmodule

// File: tb/tb_seven_seg_num.sv
// Randomised bench for seven_seg_num against a digit-arithmetic reference model.
module tb_seven_seg_num;
    localparam int DIGITS  = 4;
    localparam int WIDTH   = 16;
    localparam int REFRESH = 4;

    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E
    };

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic [15:0] num      = '0;
    logic        hex_mode = 1'b0;
    logic        blank_lz = 1'b0;
    logic [3:0]  dp_mask  = '0;
    logic [6:0]  sseg;
    logic [3:0]  an;
    logic        dp;
    logic        busy;

    int compared   = 0;
    int mismatched = 0;

    logic [3:0] s_an   [16];
    logic [6:0] s_sseg [16];
    logic       s_dp   [16];

    seven_seg_num #(.DIGITS(DIGITS), .WIDTH(WIDTH), .REFRESH_CYCLES(REFRESH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .num      (num),
        .hex_mode (hex_mode),
        .blank_lz (blank_lz),
        .dp_mask  (dp_mask),
        .sseg     (sseg),
        .an       (an),
        .dp       (dp),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Digit pos (0 = rightmost) as it should appear, from plain radix arithmetic.
    function automatic logic [6:0] model_seg(int unsigned v, bit hx, bit blz, int pos);
        int unsigned base, p, lim, d;
        base = hx ? 16 : 10;
        p = 1;
        for (int k = 0; k < pos; k++) p = p * base;
        lim = 1;
        for (int k = 0; k < DIGITS; k++) lim = lim * base;
        if (v >= lim) return 7'h3F;
        if (blz && pos > 0 && v < p) return 7'h7F;
        d = (v / p) % base;
        return GLYPH[d[3:0]];
    endfunction

    function automatic int pos_of(logic [3:0] a);
        pos_of = -1;
        for (int i = 0; i < 4; i++)
            if (a === ~(4'b0001 << i)) pos_of = i;
    endfunction

    task automatic apply_and_sample(input int unsigned v, input bit hx, input bit blz, input logic [3:0] m);
        num      = v[15:0];
        hex_mode = hx;
        blank_lz = blz;
        dp_mask  = m;
        repeat (45) @(negedge clk);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            s_an[c]   = an;
            s_sseg[c] = sseg;
            s_dp[c]   = dp;
        end
    endtask

    task automatic test_reset();
        int p;
        rst_n = 1'b0; num = 16'd1234; hex_mode = 1'b0; blank_lz = 1'b0; dp_mask = 4'b0000;
        repeat (3) @(negedge clk);
        compared++;
        if ({sseg, an, dp, busy} !== {7'h7F, 4'hF, 1'b1, 1'b0}) begin
            mismatched++;
            $display("FAIL reset_state sseg=%h an=%b dp=%b busy=%b want 7f 1111 1 0", sseg, an, dp, busy);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            if (k == 17) begin
                compared++;
                if (sseg !== 7'h7F) begin
                    mismatched++;
                    $display("FAIL reset_pre_commit sseg=%h want 7f", sseg);
                end
            end
            if (k == 19) begin
                p = pos_of(an);
                compared++;
                if (p < 0 || sseg !== model_seg(1234, 0, 0, p)) begin
                    mismatched++;
                    $display("FAIL reset_first_frame an=%b sseg=%b want digit of 1234", an, sseg);
                end
            end
        end
    endtask

    task automatic test_busy();
        int n, guard;
        num = 16'd9999; hex_mode = 1'b0;
        guard = 0;
        while (busy !== 1'b0 && guard < 100) begin @(negedge clk); guard++; end
        while (busy !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
        n = 0;
        while (busy === 1'b1 && guard < 100) begin @(negedge clk); n++; guard++; end
        compared++;
        if (guard >= 100 || n != WIDTH+1) begin
            mismatched++;
            $display("FAIL busy_high cycles=%0d want %0d (guard=%0d)", n, WIDTH+1, guard);
        end
        n = 0;
        while (busy === 1'b0 && guard < 100) begin @(negedge clk); n++; guard++; end
        compared++;
        if (guard >= 100 || n != 1) begin
            mismatched++;
            $display("FAIL busy_low cycles=%0d want 1", n);
        end
    endtask

    task automatic test_decimal();
        int unsigned vals [6];
        int p, q, prev;
        vals[0] = 9999; vals[1] = 1234;
        for (int i = 2; i < 6; i++) vals[i] = $urandom_range(9999, 0);
        for (int t = 0; t < 6; t++) begin
            apply_and_sample(vals[t], 1'b0, 1'b0, 4'b0000);
            prev = -1;
            for (int c = 0; c < 16; c++) begin
                p = pos_of(s_an[c]);
                q = (p < 0) ? 0 : p;
                compared++;
                if (p < 0 || s_sseg[c] !== model_seg(vals[t], 0, 0, q) || s_dp[c] !== 1'b1) begin
                    mismatched++;
                    $display("FAIL decimal v=%0d c=%0d an=%b sseg=%b dp=%b want sseg=%b dp=1",
                             vals[t], c, s_an[c], s_sseg[c], s_dp[c], model_seg(vals[t], 0, 0, q));
                end
                if (prev >= 0 && p != prev) begin
                    compared++;
                    if (p != ((prev == 0) ? DIGITS-1 : prev-1)) begin
                        mismatched++;
                        $display("FAIL scan_order from=%0d to=%0d", prev, p);
                    end
                end
                prev = p;
            end
        end
    endtask

    task automatic test_overflow();
        int unsigned vals [5];
        bit hx [5];
        int p, q;
        vals[0] = 10000;                       hx[0] = 1'b0;
        vals[1] = $urandom_range(65535, 10001); hx[1] = 1'b0;
        vals[2] = 16'h270F;                    hx[2] = 1'b1;
        vals[3] = $urandom_range(65535, 0);    hx[3] = 1'b1;
        vals[4] = 16'hBCDE;                    hx[4] = 1'b1;
        for (int t = 0; t < 5; t++) begin
            apply_and_sample(vals[t], hx[t], 1'b0, 4'b0000);
            for (int c = 0; c < 16; c++) begin
                p = pos_of(s_an[c]);
                q = (p < 0) ? 0 : p;
                compared++;
                if (p < 0 || s_sseg[c] !== model_seg(vals[t], hx[t], 0, q)) begin
                    mismatched++;
                    $display("FAIL ovf_hex v=%h hex=%0d c=%0d an=%b sseg=%b want %b",
                             vals[t], hx[t], c, s_an[c], s_sseg[c], model_seg(vals[t], hx[t], 0, q));
                end
            end
        end
    endtask

    task automatic test_blanking();
        int unsigned vals [6];
        bit hx [6];
        int p, q;
        vals[0] = 42;  hx[0] = 1'b0;
        vals[1] = 0;   hx[1] = 1'b0;
        vals[2] = 507; hx[2] = 1'b0;
        vals[3] = $urandom_range(999, 0);    hx[3] = 1'b0;
        vals[4] = $urandom_range(255, 0);    hx[4] = 1'b1;
        vals[5] = $urandom_range(12000, 0);  hx[5] = 1'b0;
        for (int t = 0; t < 6; t++) begin
            apply_and_sample(vals[t], hx[t], 1'b1, 4'b0000);
            for (int c = 0; c < 16; c++) begin
                p = pos_of(s_an[c]);
                q = (p < 0) ? 0 : p;
                compared++;
                if (p < 0 || s_sseg[c] !== model_seg(vals[t], hx[t], 1, q)) begin
                    mismatched++;
                    $display("FAIL blanking v=%0d hex=%0d c=%0d an=%b sseg=%b want %b",
                             vals[t], hx[t], c, s_an[c], s_sseg[c], model_seg(vals[t], hx[t], 1, q));
                end
            end
        end
    endtask

    task automatic test_dp();
        logic [3:0] masks [3];
        int unsigned v;
        int p;
        masks[0] = 4'b0010;
        masks[1] = 4'($urandom_range(15, 0));
        masks[2] = 4'b1001;
        for (int t = 0; t < 3; t++) begin
            v = (t == 0) ? 0 : 20000;
            apply_and_sample(v, 1'b0, 1'b0, masks[t]);
            for (int c = 0; c < 16; c++) begin
                p = pos_of(s_an[c]);
                compared++;
                if (p < 0 || s_dp[c] !== ~masks[t][p] || s_sseg[c] !== model_seg(v, 0, 0, p)) begin
                    mismatched++;
                    $display("FAIL dp mask=%b c=%0d an=%b dp=%b sseg=%b", masks[t], c, s_an[c], s_dp[c], s_sseg[c]);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        int guard, p;
        int unsigned v;
        num = 16'd5678; hex_mode = 1'b0; blank_lz = 1'b0; dp_mask = 4'b0000;
        guard = 0;
        while (busy !== 1'b0 && guard < 100) begin @(negedge clk); guard++; end
        while (busy !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
        compared++;
        if (guard >= 100) begin
            mismatched++;
            $display("FAIL mid_reset_sync timeout busy=%b", busy);
        end
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        compared++;
        if ({sseg, an, dp, busy} !== {7'h7F, 4'hF, 1'b1, 1'b0}) begin
            mismatched++;
            $display("FAIL mid_reset_blank sseg=%h an=%b dp=%b busy=%b want 7f 1111 1 0", sseg, an, dp, busy);
        end
        @(negedge clk);
        v = $urandom_range(9999, 0);
        num = v[15:0];
        rst_n = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            if (k == 17) begin
                compared++;
                if (busy !== 1'b1 || sseg !== 7'h7F) begin
                    mismatched++;
                    $display("FAIL mid_reset_pre_commit busy=%b sseg=%h want 1 7f", busy, sseg);
                end
            end
            if (k == 18) begin
                compared++;
                if (busy !== 1'b0) begin
                    mismatched++;
                    $display("FAIL mid_reset_commit busy=%b want 0", busy);
                end
            end
            if (k == 19) begin
                p = pos_of(an);
                compared++;
                if (p < 0 || sseg !== model_seg(v, 0, 0, p)) begin
                    mismatched++;
                    $display("FAIL mid_reset_frame v=%0d an=%b sseg=%b", v, an, sseg);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_busy();
        test_decimal();
        test_overflow();
        test_blanking();
        test_dp();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/seven_seg_num.md
Name: seven_seg_num

Overview:
- Parametrised multiplexed numeric driver for common-anode 7-segment displays.
- Takes a WIDTH-bit binary value and shows it in decimal or hex on DIGITS digits.
- Decimal conversion is sequential (double-dabble), not combinational divide/modulo.
- Adds leading-zero blanking, per-digit decimal points, an overflow indication and a configurable refresh rate.
- Sits between demo top-levels and the board display pins.

Parameters:
- DIGITS, 4: number of digits driven (1..8).
- WIDTH, 16: width of input value (1..32).
- REFRESH_CYCLES, 262144: clk cycles each digit stays lit (>=2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active-low.
- num  in  WIDTH  unsigned value to display.
- hex_mode  in  1  1 = hexadecimal, 0 = decimal.
- blank_lz  in  1  1 = blank leading zeros.
- dp_mask  in  DIGITS  1 = light decimal point of that digit (bit DIGITS-1 = leftmost).
- sseg  out  7  segments g..a, active-low.
- an  out  DIGITS  digit enables, active-low, one-cold.
- dp  out  1  decimal point, active-low.
- busy  out  1  conversion in progress.

Behaviour:
- Reset (async, rst_n=0):
  - sseg=7'h7F, an=all ones, dp=1, busy=0.
  - Display register all-blank; refresh counter 0; digit index DIGITS-1.
- Converter FSM, states IDLE -> SHIFT -> COMMIT -> IDLE:
  - IDLE: capture num, hex_mode and blank_lz; clear BCD accumulator; go to SHIFT; busy=1 from next cycle.
  - SHIFT: runs exactly WIDTH cycles. Each cycle: add 3 to every BCD nibble >=5, then shift left one bit, taking the captured value MSB first. Accumulator is 4*DIGITS bits plus an overflow sticky bit, which is set when a 1 is shifted out of the top.
  - COMMIT: write the display register atomically; busy=0; return to IDLE.
  - Free-running: a new capture starts on the cycle after COMMIT.
  - Capture-to-display latency: WIDTH+2 cycles.
  - num changes during SHIFT are ignored until the next capture.
- Hex mode:
  - Uses the same FSM timing; nibbles are taken directly from the captured value.
  - Overflow when WIDTH > 4*DIGITS and any bit above 4*DIGITS-1 is set.
- Overflow (either mode): all digits show dash (g only, 7'b0111111). dp_mask still applies.
- Leading-zero blanking (blank_lz=1):
  - Zero digits left of the first nonzero digit show blank (7'h7F).
  - The rightmost digit is never blanked, so value 0 shows "   0".
  - Blanking is computed at COMMIT.
- Glyphs: 0-9 and a-f use the team's standard active-low patterns. Hex letters are lowercase b, c, d; uppercase-form A, E, F.
- Refresh/scan:
  - Counter runs 0..REFRESH_CYCLES-1. On wrap, digit index decrements: DIGITS-1 -> ... -> 0 -> DIGITS-1 (leftmost first).
  - an, sseg and dp are registered and update one cycle after an index change.
  - an has exactly one 0 after reset exit.
  - dp = ~dp_mask[index], sampled live rather than captured.
- Reset mid-conversion: FSM returns to IDLE and the display blanks. The first valid frame appears WIDTH+2 cycles after rst_n rises.
- DIGITS=1: the index stays at 0 and an is constantly 0 after reset exit.

Decomposition:
- Package seven_seg_pkg:
  - Segment constants SEG_BLANK=7'h7F and SEG_DASH=7'h3F.
  - Glyph decode function from a 4-bit nibble to active-low segments.
  - FSM state enum {IDLE, SHIFT, COMMIT}.
- Sub-module bin2bcd_seq (params WIDTH, DIGITS):
  - Ports: start, value, bcd, ovf, done.
  - Implements the double-dabble SHIFT loop.
- The top level holds the capture/commit register, blanking logic and scan counter.

Test Plan:
- Reset: rst_n=0 held with num=1234 -> sseg=7'h7F, an=4'b1111, dp=1, busy=0. After release and WIDTH+2 cycles the display shows 1,2,3,4 leftmost-first.
- Decimal: DIGITS=4, WIDTH=16, REFRESH_CYCLES=4, num=9999, hex_mode=0 -> scan an=0111/1011/1101/1110 with sseg=7'b0010000 each; busy high for exactly 17 cycles per conversion.
- Overflow: num=10000 decimal -> all four digits 7'b0111111. Then hex_mode=1, num=16'h270F -> digits 2,7,0,f.
- Blanking: blank_lz=1, num=42 -> digits blank, blank, 4 (7'b0011001), 2 (7'b0100100). num=0 -> blank, blank, blank, 0.
- dp_mask=4'b0010, num=0 -> dp=0 only while an=4'b1101.
- Reset asserted mid-SHIFT (cycle 8) -> outputs blank immediately. After release, the first commit occurs at cycle 18 with the correct value.
